cache_fill_fsm: RTL and testbench

- Miss-handling initiator for the multicycle memory: one write-cycle memory, reads pipelined with fixed 4-cycle latency and a data_valid strobe.
- On a cache miss, issues one read per cycle for every word of the 16-byte block. Collects the returning words by counting data_valid strobes and writes each into the cache data array.
- Finishes with a one-cycle tag write.
- Sits between cache hit/miss logic and the memory port.

---
 rtl/cache_fill_fsm.sv | 135 +++++++++++++
 tb/tb_cache_fill_fsm.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_fsm.sv
// Cache miss fill sequencer: streams one block of reads into a 4-cycle pipelined memory and writes
// the returning words into the cache data array, then the tag. Option: FILL_CRITICAL_WORD_FIRST_EN.
module cache_fill_fsm #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned BLOCK_WORDS = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           miss_detected,
  input  logic [ADDR_WIDTH-1:0]          miss_address,
  input  logic                           mem_data_valid,
  input  logic [15:0]                    mem_data_out,
  output logic                           mem_enable,
  output logic                           mem_wr,
  output logic [ADDR_WIDTH-1:0]          mem_address,
  output logic                           fsm_busy,
  output logic                           cache_data_we,
  output logic [$clog2(BLOCK_WORDS)-1:0] word_index,
  output logic [15:0]                    cache_data_in,
  output logic                           cache_tag_we,
  output logic                           fill_done
);

  localparam int unsigned IW    = $clog2(BLOCK_WORDS);
  localparam int unsigned OFS   = IW + 1;
  localparam int unsigned CW    = IW + 1;
  localparam int unsigned BaseW = ADDR_WIDTH - OFS;

  localparam logic [CW-1:0] BlockCnt = CW'(BLOCK_WORDS);
  localparam logic [CW-1:0] LastCnt  = CW'(BLOCK_WORDS - 1);
  localparam logic [CW-1:0] CntOne   = CW'(1);

  typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

  state_e           state_q, state_d;
  logic [BaseW-1:0] base_q, base_d;
  logic [CW-1:0]    issue_cnt_q, issue_cnt_d;
  logic [CW-1:0]    recv_cnt_q, recv_cnt_d;
  logic [IW-1:0]    issue_off, recv_off;
`ifdef FILL_CRITICAL_WORD_FIRST_EN
  logic [IW-1:0]    crit_q, crit_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      base_q      <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
`ifdef FILL_CRITICAL_WORD_FIRST_EN
      crit_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
`ifdef FILL_CRITICAL_WORD_FIRST_EN
      crit_q      <= crit_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
`ifdef FILL_CRITICAL_WORD_FIRST_EN
    crit_d      = crit_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (miss_detected) begin
          base_d      = miss_address[ADDR_WIDTH-1:OFS];
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
`ifdef FILL_CRITICAL_WORD_FIRST_EN
          crit_d      = miss_address[OFS-1:1];
`endif
          state_d     = StFill;
        end
      end
      StFill: begin
        if (issue_cnt_q < BlockCnt) issue_cnt_d = issue_cnt_q + CntOne;
        if (mem_data_valid) begin
          recv_cnt_d = recv_cnt_q + CntOne;
          // Leaving on the last strobe means stray strobes can never over-count a block.
          if (recv_cnt_q == LastCnt) state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Word offsets within the block; only these low bits vary, so the block never carries.
  always_comb begin
`ifdef FILL_CRITICAL_WORD_FIRST_EN
    issue_off = crit_q + issue_cnt_q[IW-1:0];
    recv_off  = crit_q + recv_cnt_q[IW-1:0];
`else
    issue_off = issue_cnt_q[IW-1:0];
    recv_off  = recv_cnt_q[IW-1:0];
`endif
  end

  always_comb begin
    mem_enable    = 1'b0;
    mem_wr        = 1'b0;
    mem_address   = '0;
    fsm_busy      = 1'b0;
    cache_data_we = 1'b0;
    word_index    = '0;
    cache_data_in = mem_data_out;
    cache_tag_we  = 1'b0;
    fill_done     = 1'b0;
    unique case (state_q)
      StFill: begin
        fsm_busy      = 1'b1;
        mem_enable    = (issue_cnt_q < BlockCnt);
        mem_address   = {base_q, issue_off, 1'b0};
        cache_data_we = mem_data_valid;
        word_index    = recv_off;
      end
      StDone: begin
        fsm_busy     = 1'b1;
        cache_tag_we = 1'b1;
        fill_done    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: 4-cycle pipelined memory model, literal vector table for the first
// fills, hand sequences for reset corners, and randomized fills checked against a timeline model.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        mem_data_valid;
  logic [15:0] mem_data_out;
  logic        mem_enable, mem_wr, fsm_busy, cache_data_we, cache_tag_we, fill_done;
  logic [15:0] mem_address, cache_data_in;
  logic [2:0]  word_index;
  logic        extra_valid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cache_fill_fsm #(.ADDR_WIDTH(16), .BLOCK_WORDS(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .miss_detected (miss_detected),
    .miss_address  (miss_address),
    .mem_data_valid(mem_data_valid),
    .mem_data_out  (mem_data_out),
    .mem_enable    (mem_enable),
    .mem_wr        (mem_wr),
    .mem_address   (mem_address),
    .fsm_busy      (fsm_busy),
    .cache_data_we (cache_data_we),
    .word_index    (word_index),
    .cache_data_in (cache_data_in),
    .cache_tag_we  (cache_tag_we),
    .fill_done     (fill_done)
  );

  // Memory contents: word at 0x1230+2i holds 0xA000+i, extended to every address.
  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    logic [15:0] d;
    d = a - 16'h1230;
    return 16'hA000 + {1'b0, d[15:1]};
  endfunction

  logic [3:0]  pv = '0;
  logic [15:0] pa [4];
  always @(posedge clk) begin
    pv    <= {pv[2:0], mem_enable === 1'b1};
    pa[0] <= mem_address;
    pa[1] <= pa[0];
    pa[2] <= pa[1];
    pa[3] <= pa[2];
  end
  assign mem_data_valid = pv[3] | extra_valid;
  assign mem_data_out   = mem_fn(pa[3]);

  typedef struct {
    logic        en;
    logic [15:0] addr;
    logic        busy;
    logic        we;
    logic [2:0]  idx;
    logic [15:0] data;
    logic        tag;
    logic        chk_addr;
    logic        chk_idx;
  } exp_t;

  typedef struct {
    logic        miss;
    logic [15:0] ain;
    exp_t        e;
  } vec_t;

  function automatic exp_t idle_exp();
    exp_t e;
    e.en = 0; e.addr = '0; e.busy = 0; e.we = 0; e.idx = '0; e.data = '0; e.tag = 0;
    e.chk_addr = 1; e.chk_idx = 1;
    return e;
  endfunction

  // Expected outputs t cycles after the request edge: issues in 1..8, returns 5..12, tag at 13.
  function automatic exp_t model(input int t, input logic [15:0] a);
    exp_t        e;
    logic [15:0] base;
    int          crit, w;
    e    = idle_exp();
    base = {a[15:4], 4'h0};
`ifdef FILL_CRITICAL_WORD_FIRST_EN
    crit = int'(a[3:1]);
`else
    crit = 0;
`endif
    if (t >= 1 && t <= 13) begin
      e.busy = 1; e.chk_addr = 0; e.chk_idx = 0;
    end
    if (t >= 1 && t <= 8) begin
      w = (crit + t - 1) % 8;
      e.en = 1; e.chk_addr = 1; e.addr = base + 16'(2 * w);
    end
    if (t >= 5 && t <= 12) begin
      w = (crit + t - 5) % 8;
      e.we = 1; e.chk_idx = 1; e.idx = 3'(w); e.data = mem_fn(base + 16'(2 * w));
    end
    if (t == 13) e.tag = 1;
    return e;
  endfunction

  task automatic check(input string name, input exp_t e);
    logic ok;
    ok = (mem_enable === e.en) && (fsm_busy === e.busy) && (cache_data_we === e.we) &&
         (cache_tag_we === e.tag) && (fill_done === e.tag) && (mem_wr === 1'b0) &&
         (!e.chk_addr || mem_address === e.addr) &&
         (!e.chk_idx || (word_index === e.idx && (!e.we || cache_data_in === e.data)));
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got en=%b wr=%b addr=%h busy=%b we=%b idx=%0d data=%h tag=%b done=%b; want en=%b addr=%h busy=%b we=%b idx=%0d data=%h tag=%b",
               name, mem_enable, mem_wr, mem_address, fsm_busy, cache_data_we, word_index,
               cache_data_in, cache_tag_we, fill_done, e.en, e.addr, e.busy, e.we, e.idx,
               e.data, e.tag);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge of cycle 14 (IDLE again).
  task automatic run_fill(input logic [15:0] a, input logic chain, input logic [15:0] nxt,
                          input logic perturb);
    miss_detected = 1'b1;
    miss_address  = a;
    for (int t = 1; t <= 14; t++) begin
      @(negedge clk);
      check($sformatf("fill@%h t=%0d", a, t), model(t, a));
      if (t <= 13) begin
        miss_detected = perturb ? 1'($urandom) : 1'b0;
        miss_address  = perturb ? 16'($urandom) : a;
      end else begin
        miss_detected = chain;
        miss_address  = nxt;
      end
      if (t == 12) extra_valid = perturb ? 1'($urandom) : 1'b0;
      if (t == 13) extra_valid = 1'b0;
    end
  endtask

  task automatic idle_cycles(input int n, input logic toggle);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle", idle_exp());
      extra_valid = (toggle && i < n - 1) ? 1'($urandom) : 1'b0;
    end
  endtask

  vec_t        rows [15];
  logic [15:0] iss [8];
  int          ord [8];
  logic [15:0] dir_addr;

  initial begin
    // Literal vectors for the first fill, with a second request raised from cycle 3 and held.
`ifdef FILL_CRITICAL_WORD_FIRST_EN
    dir_addr = 16'h123A;
    iss = '{16'h123A, 16'h123C, 16'h123E, 16'h1230, 16'h1232, 16'h1234, 16'h1236, 16'h1238};
    ord = '{5, 6, 7, 0, 1, 2, 3, 4};
`else
    dir_addr = 16'h1236;
    iss = '{16'h1230, 16'h1232, 16'h1234, 16'h1236, 16'h1238, 16'h123A, 16'h123C, 16'h123E};
    ord = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif
    for (int t = 0; t <= 14; t++) begin
      rows[t].e    = idle_exp();
      rows[t].miss = (t == 0) || (t >= 3);
      rows[t].ain  = (t == 0) ? dir_addr : (t < 3) ? 16'hFFFE : 16'h5550;
      if (t >= 1 && t <= 13) begin
        rows[t].e.busy = 1; rows[t].e.chk_addr = 0; rows[t].e.chk_idx = 0;
      end
      if (t >= 1 && t <= 8) begin
        rows[t].e.en = 1; rows[t].e.chk_addr = 1; rows[t].e.addr = iss[t-1];
      end
      if (t >= 5 && t <= 12) begin
        rows[t].e.we = 1; rows[t].e.chk_idx = 1; rows[t].e.idx = 3'(ord[t-5]);
        rows[t].e.data = 16'hA000 + 16'(ord[t-5]);
      end
      if (t == 13) rows[t].e.tag = 1;
    end

    rst = 1'b1; miss_detected = 1'b0; miss_address = '0; extra_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("reset", idle_exp());
    rst = 1'b0;
    idle_cycles(5, 1'b1);

    for (int t = 0; t <= 14; t++) begin
      check($sformatf("table t=%0d", t), rows[t].e);
      miss_detected = rows[t].miss;
      miss_address  = rows[t].ain;
      if (t < 14) @(negedge clk);
    end
    run_fill(16'h5550, 1'b0, 16'h0000, 1'b0);
    idle_cycles(2, 1'b0);

    // Reset during cycle 7 of a fill; trailing returns must not write the cache.
    miss_detected = 1'b1;
    miss_address  = 16'h1236;
    for (int t = 1; t <= 14; t++) begin
      @(negedge clk);
      if (t <= 7) check($sformatf("prerst t=%0d", t), model(t, 16'h1236));
      else        check($sformatf("postrst t=%0d", t), idle_exp());
      miss_detected = 1'b0;
      rst = (t == 7);
    end
    rst = 1'b0;
    run_fill(16'h0020, 1'b0, 16'h0000, 1'b0);
    idle_cycles(2, 1'b1);

    begin
      logic [15:0] a, nxt;
      logic        ch;
      a = 16'($urandom);
      for (int i = 0; i < 20; i++) begin
        nxt = 16'($urandom);
        ch  = ($urandom % 4) == 0;
        run_fill(a, ch, nxt, 1'b1);
        if (!ch) idle_cycles(int'($urandom_range(1, 3)), 1'b1);
        a = ch ? nxt : 16'($urandom);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
